// File: rtl/flow_pkg.sv
// flow_pkg
// Shared definitions for the flow-sensor pulse generator:
//   - default millilitres per pulse and minimum pulse period
//   - BCD digit geometry used by the BCD helpers
//   - FSM state enum plus legacy-compatible 2-bit state constants
//   - bcd_is_valid(): true when every nibble of a 4-digit BCD word is 0..9
package flow_pkg;

    localparam int ML_PER_PULSE = 2;
    localparam int MIN_PERIOD   = 2;
    localparam int BCD_DIGIT_W  = 4;
    localparam int BCD_DIGITS   = 4;
    localparam int PHASE_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } flow_state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HIGH = HIGH;
    localparam logic [1:0] ST_LOW  = LOW;
    localparam logic [1:0] ST_DONE = DONE;

    // A word is usable as a volume only if no nibble holds A..F.
    function automatic logic bcd_is_valid(input logic [BCD_DIGITS*BCD_DIGIT_W-1:0] value);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (value[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/flow_pulse_gen_bcd_dec4.sv
// bcd_dec4
// Purely combinational 4-digit BCD subtractor with saturation at zero.
// Ports:
//   value  [15:0] in  : minuend, 4 BCD digits
//   dec    [3:0]  in  : amount to subtract from the units digit (0..9)
//   result [15:0] out : value - dec in BCD, or 0000 if that would go negative
module bcd_dec4
    import flow_pkg::*;
(
    input  logic [15:0] value,
    input  logic [3:0]  dec,
    output logic [15:0] result
);

    logic [15:0] diff_digits;
    logic        borrow;
    logic [4:0]  diff;

    // Ripple the borrow from the units digit upwards. A negative 5-bit
    // difference means the digit wrapped, so add ten back (mod 16 on the
    // low nibble gives the right BCD digit). A borrow out of the top digit
    // means the true result is negative, so clamp to zero.
    always_comb begin
        diff_digits = '0;
        borrow      = 1'b0;
        diff        = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i == 0) begin
                diff = {1'b0, value[BCD_DIGIT_W-1:0]} - {1'b0, dec};
            end else begin
                diff = {1'b0, value[i*BCD_DIGIT_W +: BCD_DIGIT_W]} - {4'b0000, borrow};
            end
            if (diff[4]) begin
                diff_digits[i*BCD_DIGIT_W +: BCD_DIGIT_W] = diff[3:0] + 4'd10;
                borrow = 1'b1;
            end else begin
                diff_digits[i*BCD_DIGIT_W +: BCD_DIGIT_W] = diff[3:0];
                borrow = 1'b0;
            end
        end
        result = borrow ? 16'h0000 : diff_digits;
    end

endmodule

// File: rtl/flow_pulse_gen.sv
// flow_pulse_gen
// Emulates a flow-sensor pulse train for a dose of target_ml millilitres,
// one pulse per ML_PER_PULSE mL, with a programmable pulse period.
// Ports:
//   clk            in  : system clock, all state changes on rising edge
//   reset          in  : synchronous active-high reset
//   start          in  : begin a dose (only looked at in IDLE)
//   abort          in  : end an active dose early
//   target_ml      in  : 4-digit BCD target volume
//   period_cycles  in  : pulse period in clocks (clamped up to MIN_PERIOD)
//   pulse          out : emulated sensor pulse
//   remaining_ml   out : BCD volume still to be emitted
//   busy           out : high while pulsing (HIGH/LOW)
//   done           out : one-cycle strobe at end of dose or abort
//   err            out : sticky flag for a non-BCD target
module flow_pulse_gen #(
    parameter int ML_PER_PULSE = flow_pkg::ML_PER_PULSE,
    parameter int MIN_PERIOD   = flow_pkg::MIN_PERIOD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] target_ml,
    input  logic [15:0] period_cycles,
    output logic        pulse,
    output logic [15:0] remaining_ml,
    output logic        busy,
    output logic        done,
    output logic        err
);

    import flow_pkg::ST_IDLE;
    import flow_pkg::ST_HIGH;
    import flow_pkg::ST_LOW;
    import flow_pkg::ST_DONE;
    import flow_pkg::PHASE_W;
    import flow_pkg::bcd_is_valid;

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [PHASE_W-1:0] phase_cnt;
    logic [PHASE_W-1:0] high_len;
    logic [PHASE_W-1:0] low_len;
    logic [PHASE_W-1:0] eff_period;
    logic               target_ok;
    logic               target_zero;
    logic               phase_end;
    logic [15:0]        dec_src;
    logic [15:0]        dec_result;

    // In IDLE the first decrement is taken straight from the incoming
    // target, so the first pulse already shows the reduced volume.
    assign dec_src = (state == ST_IDLE) ? target_ml : remaining_ml;

    bcd_dec4 u_dec (
        .value  (dec_src),
        .dec    (4'(ML_PER_PULSE)),
        .result (dec_result)
    );

    // Input qualification and the end-of-phase test for the current state.
    always_comb begin
        target_ok   = bcd_is_valid(target_ml);
        target_zero = (target_ml == 16'h0000);
        eff_period  = (period_cycles < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period_cycles;
        if (state == ST_HIGH) begin
            phase_end = (phase_cnt == high_len - 16'd1);
        end else begin
            phase_end = (phase_cnt == low_len - 16'd1);
        end
    end

    // Next-state logic. Abort wins over the phase timer, which makes the
    // abort-at-end-of-LOW case land in DONE exactly like a natural finish.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start && target_ok) begin
                    next_state = target_zero ? ST_DONE : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    next_state = ST_DONE;
                end else if (phase_end) begin
                    next_state = ST_LOW;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    next_state = ST_DONE;
                end else if (phase_end) begin
                    next_state = (remaining_ml != 16'h0000) ? ST_HIGH : ST_DONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and the dose bookkeeping. Outputs are
    // decoded from next_state so they line up with the state register and
    // never see an input combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pulse        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            remaining_ml <= 16'h0000;
            phase_cnt    <= '0;
            high_len     <= '0;
            low_len      <= '0;
        end else begin
            state <= next_state;
            pulse <= (next_state == ST_HIGH);
            busy  <= (next_state == ST_HIGH) || (next_state == ST_LOW);
            done  <= (next_state == ST_DONE);

            if ((next_state != state) || (next_state == ST_IDLE) || (next_state == ST_DONE)) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 16'd1;
            end

            if ((state == ST_IDLE) && start) begin
                if (target_ok) begin
                    err          <= 1'b0;
                    high_len     <= eff_period >> 1;
                    low_len      <= eff_period - (eff_period >> 1);
                    remaining_ml <= target_zero ? target_ml : dec_result;
                end else begin
                    err <= 1'b1;
                end
            end else if ((state == ST_LOW) && (next_state == ST_HIGH)) begin
                remaining_ml <= dec_result;
            end
        end
    end

endmodule

// File: tb/tb_flow_pulse_gen.sv
// tb_flow_pulse_gen
// Self-checking bench for flow_pulse_gen. Expected outputs for every cycle
// of a dose come from a closed-form description of the pulse train (pulse
// index and phase from the cycle number, remaining volume in plain decimal
// converted to BCD), not from any state machine.
module tb_flow_pulse_gen;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] target_ml = 16'h0000;
    logic [15:0] period_cycles = 16'd0;
    logic        pulse;
    logic [15:0] remaining_ml;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_rem = 16'h0000;

    flow_pulse_gen #(
        .ML_PER_PULSE (ML),
        .MIN_PERIOD   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .target_ml     (target_ml),
        .period_cycles (period_cycles),
        .pulse         (pulse),
        .remaining_ml  (remaining_ml),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Last cycle (counted from the start edge) on which the dose is busy.
    function automatic int dose_stop(input int t, input int per, input int ab);
        int p, n, last;
        p = (per < 2) ? 2 : per;
        n = (t + ML - 1) / ML;
        last = n * p;
        if (ab >= 1 && ab <= last) last = ab;
        return last;
    endfunction

    // Expected {pulse, busy, done, err, remaining_ml} in cycle c after start.
    function automatic logic [19:0] model(input int c, input int t, input int per, input int ab);
        int p, h, k, ph, stop, r;
        p = (per < 2) ? 2 : per;
        h = p / 2;
        stop = dose_stop(t, per, ab);
        if (c <= stop) begin
            k = (c - 1) / p;
            ph = (c - 1) % p;
            r = t - (k + 1) * ML;
            if (r < 0) r = 0;
            return {(ph < h), 1'b1, 1'b0, 1'b0, to_bcd(r)};
        end
        if (stop == 0) begin
            r = 0;
        end else begin
            k = (stop - 1) / p;
            r = t - (k + 1) * ML;
            if (r < 0) r = 0;
        end
        return {1'b0, 1'b0, (c == stop + 1), 1'b0, to_bcd(r)};
    endfunction

    // One full dose: start at cycle 0, optional abort driven in cycle ab,
    // optional junk on start/target/period while the dose is running.
    task automatic run_dose(input string name, input int t, input int per, input int ab, input bit junk);
        int stop;
        logic [19:0] exp_v, act_v;
        stop = dose_stop(t, per, ab);
        @(negedge clk);
        target_ml = to_bcd(t);
        period_cycles = 16'(per);
        start = 1'b1;
        abort = 1'b0;
        for (int c = 1; c <= stop + 2; c++) begin
            @(negedge clk);
            exp_v = model(c, t, per, ab);
            act_v = {pulse, busy, done, err, remaining_ml};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got {pulse,busy,done,err,rem}=%h, want %h", name, c, act_v, exp_v);
            end
            start = (junk && c <= stop + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (junk) begin
                target_ml = 16'($urandom);
                period_cycles = 16'($urandom_range(0, 9));
            end
            abort = (ab != 0 && c == ab);
        end
        start = 1'b0;
        abort = 1'b0;
        last_rem = model(stop + 2, t, per, ab) & 20'h0FFFF;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pulse, busy, done, err, remaining_ml} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset: got %h, want 00000", {pulse, busy, done, err, remaining_ml});
        end
        reset = 1'b0;
        last_rem = 16'h0000;
    endtask

    task automatic test_normal;
        run_dose("normal_0010_p4", 10, 4, 0, 1'b0);
        run_dose("odd_0007_p4", 7, 4, 0, 1'b0);
        run_dose("borrow_0100_p2", 100, 2, 0, 1'b0);
        run_dose("period0_0006", 6, 0, 0, 1'b0);
        run_dose("period5_0005", 5, 5, 0, 1'b0);
        run_dose("zero_target", 0, 3, 0, 1'b0);
    endtask

    task automatic test_abort;
        run_dose("abort_3rd_high", 10, 4, 9, 1'b0);
    endtask

    task automatic test_invalid_bcd;
        logic [15:0] bad [2];
        bad[0] = 16'h00A0;
        bad[1] = 16'hF123;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            target_ml = bad[b];
            period_cycles = 16'd4;
            start = 1'b1;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                start = 1'b0;
                checks++;
                if ({pulse, busy, done, err, remaining_ml} !== {4'b0001, last_rem}) begin
                    errors++;
                    $display("[TB] FAIL invalid_bcd %h cycle %0d: got %h, want %h", bad[b], c,
                             {pulse, busy, done, err, remaining_ml}, {4'b0001, last_rem});
                end
            end
        end
    endtask

    task automatic test_abort_at_low_end;
        run_dose("abort_end_low", 4, 4, 8, 1'b0);
        run_dose("abort_in_done", 4, 4, 9, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            int t, per, ab, last;
            t = $urandom_range(0, 60);
            per = $urandom_range(0, 7);
            last = dose_stop(t, per, 0);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, last + 2) : 0;
            run_dose("random_dose", t, per, ab, 1'b1);
        end
    endtask

    task automatic test_reset_mid_dose;
        logic [19:0] exp_v;
        @(negedge clk);
        target_ml = to_bcd(10);
        period_cycles = 16'd4;
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        exp_v = model(3, 10, 4, 0);
        checks++;
        if ({pulse, busy, done, err, remaining_ml} !== exp_v) begin
            errors++;
            $display("[TB] FAIL pre_reset_low: got %h, want %h", {pulse, busy, done, err, remaining_ml}, exp_v);
        end
        reset = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({pulse, busy, done, err, remaining_ml} !== 20'h0) begin
                errors++;
                $display("[TB] FAIL reset_mid_dose step %0d: got %h, want 00000", c, {pulse, busy, done, err, remaining_ml});
            end
            @(negedge clk);
        end
        last_rem = 16'h0000;
        run_dose("after_reset_0010", 10, 4, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_abort();
        test_invalid_bcd();
        test_abort_at_low_end();
        test_back_to_back();
        test_reset_mid_dose();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
